// File: rtl/mem_responder_if.sv
// Accelerator memory-port bundle: burst request, write beats, read beats and responder status.
// The initiator drives through master; the responder implements slave.
interface mem_responder_if #(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 64,
  parameter int unsigned MEM_DATA_BITS = 64
);
  logic                     dpi_req_valid;
  logic                     dpi_req_opcode;
  logic [MEM_LEN_BITS-1:0]  dpi_req_len;
  logic [MEM_ADDR_BITS-1:0] dpi_req_addr;
  logic                     dpi_wr_valid;
  logic [MEM_DATA_BITS-1:0] dpi_wr_bits;
  logic                     dpi_rd_valid;
  logic [MEM_DATA_BITS-1:0] dpi_rd_bits;
  logic                     dpi_rd_ready;
  logic                     busy;
  logic                     err;

  modport master (
    output dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr,
    output dpi_wr_valid, dpi_wr_bits, dpi_rd_ready,
    input  dpi_rd_valid, dpi_rd_bits, busy, err
  );

  modport slave (
    input  dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr,
    input  dpi_wr_valid, dpi_wr_bits, dpi_rd_ready,
    output dpi_rd_valid, dpi_rd_bits, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Burst memory responder backed by a local word array, with a sticky flag that records
// initiator protocol violations. All outputs are registered.
module mem_responder #(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 64,
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned DEPTH_LOG2    = 10
) (
  input logic            clock,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int unsigned B     = $clog2(MEM_DATA_BITS / 8);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0]    idx_t;
  typedef logic [MEM_LEN_BITS-1:0]  cnt_t;
  typedef logic [MEM_DATA_BITS-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  cnt_t   cnt_q, cnt_d;
  logic   rd_valid_q, rd_valid_d;
  word_t  rd_bits_q, rd_bits_d;
  logic   err_q, err_d;
  logic   mem_we;
  word_t  mem_q [Depth];

  idx_t req_idx, idx_inc;
  logic rd_fire, violation;
  logic unused_addr;

  // Only the word-index slice of the address matters; the rest wraps or is ignored.
  assign req_idx     = bus.dpi_req_addr[DEPTH_LOG2+B-1:B];
  assign unused_addr = ^bus.dpi_req_addr;
  assign idx_inc     = idx_q + idx_t'(1);
  assign rd_fire     = rd_valid_q && bus.dpi_rd_ready;
  assign violation   = (bus.dpi_req_valid && state_q != StIdle) ||
                       (bus.dpi_wr_valid && state_q != StWrite);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.dpi_req_valid) state_d = bus.dpi_req_opcode ? StWrite : StRead;
      StRead:  if (rd_fire && cnt_q == '0) state_d = StIdle;
      StWrite: if (bus.dpi_wr_valid && cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; offending events fall through untouched apart from err.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_bits_d  = rd_bits_q;
    err_d      = err_q | violation;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.dpi_req_valid) begin
          idx_d = req_idx;
          cnt_d = bus.dpi_req_len;
          if (!bus.dpi_req_opcode) begin
            rd_valid_d = 1'b1;
            rd_bits_d  = mem_q[req_idx];
          end
        end
      end
      StRead: begin
        if (rd_fire) begin
          if (cnt_q != '0) begin
            idx_d     = idx_inc;
            cnt_d     = cnt_q - cnt_t'(1);
            rd_bits_d = mem_q[idx_inc];
          end else begin
            rd_valid_d = 1'b0;
          end
        end
      end
      StWrite: begin
        if (bus.dpi_wr_valid) begin
          mem_we = 1'b1;
          idx_d  = idx_inc;
          if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_bits_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_bits_q  <= rd_bits_d;
      err_q      <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem_q[idx_q] <= bus.dpi_wr_bits;
  end

  always_comb begin
    bus.dpi_rd_valid = rd_valid_q;
    bus.dpi_rd_bits  = rd_bits_q;
    bus.busy         = (state_q != StIdle);
    bus.err          = err_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: bursts, backpressure, wrap, violations, reset, misalignment.
module tb_mem_responder;
  localparam int unsigned LenBits   = 8;
  localparam int unsigned AddrBits  = 64;
  localparam int unsigned DataBits  = 64;
  localparam int unsigned DepthLog2 = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_responder_if #(
    .MEM_LEN_BITS (LenBits),
    .MEM_ADDR_BITS(AddrBits),
    .MEM_DATA_BITS(DataBits)
  ) bus_if ();

  mem_responder #(
    .MEM_LEN_BITS (LenBits),
    .MEM_ADDR_BITS(AddrBits),
    .MEM_DATA_BITS(DataBits),
    .DEPTH_LOG2   (DepthLog2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_buf [16];
  logic [6:0]  pat;
  logic [63:0] prev_bits;
  int          nb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.dpi_req_valid  = 1'b0;
    bus_if.dpi_req_opcode = 1'b0;
    bus_if.dpi_req_len    = '0;
    bus_if.dpi_req_addr   = '0;
    bus_if.dpi_wr_valid   = 1'b0;
    bus_if.dpi_wr_bits    = '0;
    bus_if.dpi_rd_ready   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic send_req(input logic op, input logic [63:0] addr, input int len);
    bus_if.dpi_req_valid  = 1'b1;
    bus_if.dpi_req_opcode = op;
    bus_if.dpi_req_addr   = addr;
    bus_if.dpi_req_len    = LenBits'(len);
  endtask

  task automatic write_burst(input logic [63:0] addr, input int len);
    send_req(1'b1, addr, len);
    step();
    bus_if.dpi_req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus_if.dpi_wr_valid = 1'b1;
      bus_if.dpi_wr_bits  = exp_buf[i];
      step();
    end
    bus_if.dpi_wr_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [63:0] addr, input int len);
    send_req(1'b0, addr, len);
    bus_if.dpi_rd_ready = 1'b1;
    step();
    bus_if.dpi_req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      check_eq($sformatf("%s_valid%0d", tag, i), {63'd0, bus_if.dpi_rd_valid}, 64'd1);
      check_eq($sformatf("%s_beat%0d", tag, i), bus_if.dpi_rd_bits, exp_buf[i]);
      step();
    end
    check_eq({tag, "_done_valid"}, {63'd0, bus_if.dpi_rd_valid}, 64'd0);
    check_eq({tag, "_done_busy"}, {63'd0, bus_if.busy}, 64'd0);
    bus_if.dpi_rd_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    check_eq("rst_valid", {63'd0, bus_if.dpi_rd_valid}, 64'd0);
    check_eq("rst_bits", bus_if.dpi_rd_bits, 64'd0);
    check_eq("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check_eq("rst_err", {63'd0, bus_if.err}, 64'd0);
    reset = 1'b1;

    // 1: write then read back
    exp_buf[0] = 64'h11; exp_buf[1] = 64'h22; exp_buf[2] = 64'h33; exp_buf[3] = 64'h44;
    write_burst(64'h40, 3);
    check_eq("t1_wr_busy", {63'd0, bus_if.busy}, 64'd0);
    read_check("t1_rd", 64'h40, 3);
    check_eq("t1_err", {63'd0, bus_if.err}, 64'd0);

    // 2: backpressure, ready sequence 1,0,0,1,1,0,1
    pat = 7'b1011001;
    send_req(1'b0, 64'h40, 3);
    step();
    bus_if.dpi_req_valid = 1'b0;
    nb = 0;
    prev_bits = '0;
    for (int i = 0; i < 7; i++) begin
      bus_if.dpi_rd_ready = pat[i];
      check_eq($sformatf("t2_valid%0d", i), {63'd0, bus_if.dpi_rd_valid}, 64'd1);
      if (i > 0 && !pat[i-1])
        check_eq($sformatf("t2_hold%0d", i), bus_if.dpi_rd_bits, prev_bits);
      if (pat[i]) begin
        check_eq($sformatf("t2_beat%0d", nb), bus_if.dpi_rd_bits, exp_buf[nb]);
        nb++;
      end
      prev_bits = bus_if.dpi_rd_bits;
      step();
    end
    check_eq("t2_done_valid", {63'd0, bus_if.dpi_rd_valid}, 64'd0);
    bus_if.dpi_rd_ready = 1'b0;

    // 3: wrap from word 1023 to word 0
    exp_buf[0] = 64'hA; exp_buf[1] = 64'hB;
    write_burst(64'h1FF8, 1);
    read_check("t3_top", 64'h1FF8, 1);
    exp_buf[0] = 64'hB;
    read_check("t3_w0", 64'h0, 0);
    check_eq("t3_err", {63'd0, bus_if.err}, 64'd0);

    // 4a: request while a read is in flight
    exp_buf[0] = 64'h1; exp_buf[1] = 64'h2; exp_buf[2] = 64'h3; exp_buf[3] = 64'h4;
    write_burst(64'h100, 3);
    send_req(1'b0, 64'h100, 3);
    bus_if.dpi_rd_ready = 1'b1;
    step();
    check_eq("t4a_beat0", bus_if.dpi_rd_bits, 64'h1);
    send_req(1'b1, 64'h0, 0);
    step();
    bus_if.dpi_req_valid = 1'b0;
    check_eq("t4a_err", {63'd0, bus_if.err}, 64'd1);
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("t4a_beat%0d", i), bus_if.dpi_rd_bits, exp_buf[i]);
      step();
    end
    check_eq("t4a_done_valid", {63'd0, bus_if.dpi_rd_valid}, 64'd0);
    check_eq("t4a_done_busy", {63'd0, bus_if.busy}, 64'd0);
    bus_if.dpi_rd_ready = 1'b0;

    // 4b: write beat while idle
    do_reset();
    check_eq("t4b_err_clr", {63'd0, bus_if.err}, 64'd0);
    bus_if.dpi_wr_valid = 1'b1;
    bus_if.dpi_wr_bits  = 64'hDEAD;
    step();
    bus_if.dpi_wr_valid = 1'b0;
    check_eq("t4b_err", {63'd0, bus_if.err}, 64'd1);
    check_eq("t4b_busy", {63'd0, bus_if.busy}, 64'd0);
    exp_buf[0] = 64'hB;
    read_check("t4b_w0", 64'h0, 0);

    // 4c: write beat in the same cycle as the write request
    do_reset();
    send_req(1'b1, 64'h200, 0);
    bus_if.dpi_wr_valid = 1'b1;
    bus_if.dpi_wr_bits  = 64'hBAD;
    step();
    bus_if.dpi_req_valid = 1'b0;
    bus_if.dpi_wr_valid  = 1'b0;
    check_eq("t4c_err", {63'd0, bus_if.err}, 64'd1);
    check_eq("t4c_busy", {63'd0, bus_if.busy}, 64'd1);
    bus_if.dpi_wr_valid = 1'b1;
    bus_if.dpi_wr_bits  = 64'h77;
    step();
    bus_if.dpi_wr_valid = 1'b0;
    check_eq("t4c_done_busy", {63'd0, bus_if.busy}, 64'd0);
    exp_buf[0] = 64'h77;
    read_check("t4c_data", 64'h200, 0);
    exp_buf[0] = 64'hB;
    read_check("t4c_w0", 64'h0, 0);

    // 5: reset during beat 2 of a len=7 read (err is still set from 4c)
    for (int i = 0; i < 8; i++) exp_buf[i] = 64'h50 + 64'(i);
    write_burst(64'h300, 7);
    send_req(1'b0, 64'h300, 7);
    bus_if.dpi_rd_ready = 1'b1;
    step();
    bus_if.dpi_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t5_pre%0d", i), bus_if.dpi_rd_bits, exp_buf[i]);
      if (i < 2) step();
    end
    reset = 1'b0;
    step();
    check_eq("t5_valid", {63'd0, bus_if.dpi_rd_valid}, 64'd0);
    check_eq("t5_bits", bus_if.dpi_rd_bits, 64'd0);
    check_eq("t5_busy", {63'd0, bus_if.busy}, 64'd0);
    check_eq("t5_err", {63'd0, bus_if.err}, 64'd0);
    reset = 1'b1;
    bus_if.dpi_rd_ready = 1'b0;
    read_check("t5_reread", 64'h300, 7);

    // 6: low address bits are ignored
    exp_buf[0] = 64'h11; exp_buf[1] = 64'h22;
    read_check("t6_45", 64'h45, 0);
    read_check("t6_47", 64'h47, 1);
    check_eq("t6_err", {63'd0, bus_if.err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
